// File: rtl/sample_buffer.sv
// Training-sample store: loads {target, x} pairs while idle, then replays them one per iteration.
// Optional continuous replay with stop_i is enabled by defining SAMPLE_BUFFER_LOOP_EN.
module sample_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned X_W   = 4,
    parameter int unsigned T_W   = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       wr_en_i,
    input  logic [X_W+T_W-1:0]         wr_data_i,
    input  logic                       start_i,
    input  logic                       next_i,
    input  logic                       stop_i,
    output logic [X_W-1:0]             x_o,
    output logic [T_W-1:0]             target_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       overflow_o,
    output logic                       epoch_done_o,
    output logic [7:0]                 epoch_cnt_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned DW = X_W + T_W;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DW-1:0]   sample_q, sample_d;
    logic            valid_q, valid_d;
    logic            overflow_q, overflow_d;
    logic            epoch_done_q, epoch_done_d;
    logic [7:0]      epoch_cnt_q, epoch_cnt_d;

    logic [DW-1:0]   mem_q [DEPTH];
    logic            mem_we;
    logic            full;
    logic            last;
    logic [PW-1:0]   rd_next;

    assign full    = (count_q == CW'(DEPTH));
    assign last    = ({1'b0, rd_ptr_q} == (count_q - CW'(1)));
    assign rd_next = rd_ptr_q + PW'(1);

`ifndef SAMPLE_BUFFER_LOOP_EN
    logic unused_stop;
    assign unused_stop = stop_i;
`endif

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        sample_d     = sample_q;
        valid_d      = valid_q;
        overflow_d   = overflow_q;
        epoch_done_d = 1'b0;
        epoch_cnt_d  = epoch_cnt_q;
        mem_we       = 1'b0;

        if (clear_i) begin
            state_d     = StIdle;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            sample_d    = '0;
            valid_d     = 1'b0;
            overflow_d  = 1'b0;
            epoch_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (wr_en_i) begin
                        if (full) begin
                            overflow_d = 1'b1;
                        end else begin
                            mem_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + PW'(1);
                            count_d  = count_q + CW'(1);
                        end
                    end
                    // A write landing in an empty buffer is slot 0; bypass the array.
                    if (start_i && (count_q != '0 || mem_we)) begin
                        state_d  = StRun;
                        rd_ptr_d = '0;
                        valid_d  = 1'b1;
                        sample_d = (count_q == '0) ? wr_data_i : mem_q[0];
                    end
                end
                StRun: begin
                    if (wr_en_i) begin
                        overflow_d = 1'b1;
                    end
`ifdef SAMPLE_BUFFER_LOOP_EN
                    if (stop_i) begin
                        state_d  = StIdle;
                        rd_ptr_d = '0;
                        valid_d  = 1'b0;
                        sample_d = '0;
                    end else
`endif
                    if (next_i) begin
                        if (last) begin
                            epoch_done_d = 1'b1;
                            if (epoch_cnt_q != 8'hFF) begin
                                epoch_cnt_d = epoch_cnt_q + 8'd1;
                            end
                            rd_ptr_d = '0;
`ifdef SAMPLE_BUFFER_LOOP_EN
                            sample_d = mem_q[0];
`else
                            state_d  = StIdle;
                            valid_d  = 1'b0;
                            sample_d = '0;
`endif
                        end else begin
                            rd_ptr_d = rd_next;
                            sample_d = mem_q[rd_next];
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            sample_q     <= '0;
            valid_q      <= 1'b0;
            overflow_q   <= 1'b0;
            epoch_done_q <= 1'b0;
            epoch_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            sample_q     <= sample_d;
            valid_q      <= valid_d;
            overflow_q   <= overflow_d;
            epoch_done_q <= epoch_done_d;
            epoch_cnt_q  <= epoch_cnt_d;
        end
    end

    // Storage needs no reset; only slots below count_q are ever read.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign x_o          = sample_q[X_W-1:0];
    assign target_o     = sample_q[DW-1:X_W];
    assign valid_o      = valid_q;
    assign count_o      = count_q;
    assign full_o       = full;
    assign empty_o      = (count_q == '0);
    assign overflow_o   = overflow_q;
    assign epoch_done_o = epoch_done_q;
    assign epoch_cnt_o  = epoch_cnt_q;

endmodule

// File: tb/tb_sample_buffer.sv
// Directed bench for sample_buffer: a scoreboard queue holds the expected replay order,
// flags and counters are checked against constants after each step.
module tb_sample_buffer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       clear_i, wr_en_i, start_i, next_i, stop_i;
    logic [7:0] wr_data_i;
    logic [3:0] x_o, target_o;
    logic       valid_o, full_o, empty_o, overflow_o, epoch_done_o;
    logic [2:0] count_o;
    logic [7:0] epoch_cnt_o;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb_q[$];
    logic [7:0] model[$];

    always #5 clk_i = ~clk_i;

    sample_buffer #(.DEPTH(4), .X_W(4), .T_W(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .wr_en_i     (wr_en_i),
        .wr_data_i   (wr_data_i),
        .start_i     (start_i),
        .next_i      (next_i),
        .stop_i      (stop_i),
        .x_o         (x_o),
        .target_o    (target_o),
        .valid_o     (valid_o),
        .count_o     (count_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .overflow_o  (overflow_o),
        .epoch_done_o(epoch_done_o),
        .epoch_cnt_o (epoch_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write(input logic [7:0] d);
        wr_en_i   = 1'b1;
        wr_data_i = d;
        if (model.size() < 4) model.push_back(d);
        step();
        wr_en_i = 1'b0;
    endtask

    // Expected replay order is queued when start is driven.
    task automatic start_replay();
        foreach (model[i]) sb_q.push_back(model[i]);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        e = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
        check({tag, "_valid"}, 32'(valid_o), 32'd1);
        check({tag, "_sample"}, {24'd0, target_o, x_o}, {24'd0, e});
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        model.delete();
        sb_q.delete();
    endtask

    initial begin
        rst_i = 1'b0; clear_i = 1'b0; wr_en_i = 1'b0; start_i = 1'b0;
        next_i = 1'b0; stop_i = 1'b0; wr_data_i = '0;
        #12;
        check("rst_valid", 32'(valid_o), 0);
        check("rst_count", 32'(count_o), 0);
        check("rst_empty", 32'(empty_o), 1);
        check("rst_full", 32'(full_o), 0);
        check("rst_ovf", 32'(overflow_o), 0);
        check("rst_sample", {24'd0, target_o, x_o}, 0);
        rst_i = 1'b1;
        step();

        // Three writes, then fill and overflow
        write(8'h12); write(8'h34); write(8'h56);
        check("w3_count", 32'(count_o), 3);
        check("w3_empty", 32'(empty_o), 0);
        check("w3_full", 32'(full_o), 0);
        write(8'h78);
        check("w4_full", 32'(full_o), 1);
        check("w4_ovf", 32'(overflow_o), 0);
        write(8'h99);
        check("w5_ovf", 32'(overflow_o), 1);
        check("w5_count", 32'(count_o), 4);
        check("w5_full", 32'(full_o), 1);

        // Replay all four samples
        start_replay();
        pop_check("rep0");
        next_i = 1'b1;
        step(); pop_check("rep1");
        step(); pop_check("rep2");
        step(); pop_check("rep3");
        step();
        next_i = 1'b0;
        check("ep1_done", 32'(epoch_done_o), 1);
        check("ep1_cnt", 32'(epoch_cnt_o), 1);
`ifdef SAMPLE_BUFFER_LOOP_EN
        check("ep1_valid", 32'(valid_o), 1);
        check("ep1_wrap", {24'd0, target_o, x_o}, 32'h12);
        stop_i = 1'b1; next_i = 1'b1;
        step();
        stop_i = 1'b0; next_i = 1'b0;
        check("stop_valid", 32'(valid_o), 0);
        check("stop_nodone", 32'(epoch_done_o), 0);
        check("stop_count", 32'(count_o), 4);
`else
        check("ep1_valid", 32'(valid_o), 0);
        step();
`endif
        check("ep1_done_clr", 32'(epoch_done_o), 0);

        // Two-sample load, replay
        do_clear();
        check("clr_count", 32'(count_o), 0);
        check("clr_ovf", 32'(overflow_o), 0);
        check("clr_epoch", 32'(epoch_cnt_o), 0);
        write(8'h21); write(8'h43);
        start_replay();
        pop_check("two0");
        check("two0_x", 32'(x_o), 1);
        next_i = 1'b1;
        step();
        pop_check("two1");
        step();
        next_i = 1'b0;
        check("two_done", 32'(epoch_done_o), 1);
        check("two_cnt", 32'(epoch_cnt_o), 1);
`ifdef SAMPLE_BUFFER_LOOP_EN
        check("two_wrap_x", 32'(x_o), 1);
        stop_i = 1'b1; step(); stop_i = 1'b0;
`else
        check("two_valid", 32'(valid_o), 0);
        check("two_x_zero", 32'(x_o), 0);
`endif

        // Write while running is dropped, then clear mid-run
        start_replay();
        pop_check("wrrun0");
        wr_en_i = 1'b1; wr_data_i = 8'hEE;
        step();
        wr_en_i = 1'b0;
        check("wrrun_ovf", 32'(overflow_o), 1);
        check("wrrun_count", 32'(count_o), 2);
        sb_q.delete();
        do_clear();
        check("clrrun_valid", 32'(valid_o), 0);
        check("clrrun_count", 32'(count_o), 0);
        check("clrrun_epoch", 32'(epoch_cnt_o), 0);

        // Start on empty buffer is ignored
        start_i = 1'b1; step(); start_i = 1'b0;
        check("empty_start", 32'(valid_o), 0);

        // Write and start in the same cycle on an empty buffer
        model.push_back(8'hAB);
        sb_q.push_back(8'hAB);
        wr_en_i = 1'b1; wr_data_i = 8'hAB; start_i = 1'b1;
        step();
        wr_en_i = 1'b0; start_i = 1'b0;
        pop_check("same_cycle");
        check("same_count", 32'(count_o), 1);

        // Async reset mid-run
        #2;
        rst_i = 1'b0;
        #1;
        check("arst_valid", 32'(valid_o), 0);
        check("arst_count", 32'(count_o), 0);
        check("arst_sample", {24'd0, target_o, x_o}, 0);
        check("arst_empty", 32'(empty_o), 1);
        rst_i = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
